// File: rtl/axi4_burst_master.sv
// axi4_burst_master: one-command-at-a-time AXI4 burst master (AR/R or AW/W/B) with stream-side data ports.
// Define AXI_BURST_MASTER_TIMEOUT_EN to add a 16-bit watchdog that aborts a stalled transaction.
module axi4_burst_master #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW / 8,
    parameter int IW = 1,
    parameter int LW = 8
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [DW-1:0] wd_data,
    input  logic [SW-1:0] wd_strb,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          sts_valid,
    output logic [1:0]    sts_resp,
    output logic          sts_err,
    output logic [IW-1:0] ARID,
    output logic [AW-1:0] ARADDR,
    output logic [LW-1:0] ARLEN,
    output logic [2:0]    ARSIZE,
    output logic [1:0]    ARBURST,
    output logic          ARVALID,
    input  logic          ARREADY,
    input  logic [IW-1:0] RID,
    input  logic [DW-1:0] RDATA,
    input  logic [1:0]    RRESP,
    input  logic          RLAST,
    input  logic          RVALID,
    output logic          RREADY,
    output logic [IW-1:0] AWID,
    output logic [AW-1:0] AWADDR,
    output logic [LW-1:0] AWLEN,
    output logic [2:0]    AWSIZE,
    output logic [1:0]    AWBURST,
    output logic          AWVALID,
    input  logic          AWREADY,
    output logic [DW-1:0] WDATA,
    output logic [SW-1:0] WSTRB,
    output logic          WLAST,
    output logic          WVALID,
    input  logic          WREADY,
    input  logic [IW-1:0] BID,
    input  logic [1:0]    BRESP,
    input  logic          BVALID,
    output logic          BREADY
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B, STS} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW:0] cnt_q, cnt_d;
    logic [1:0] resp_q, resp_d;
    logic err_q, err_d, aw_done_q, aw_done_d, w_done_q, w_done_d, last;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    logic [15:0] wdt_q, wdt_d;
    logic hs;
`endif

    // Severity rank: EXOKAY < OKAY < SLVERR < DECERR
    function automatic logic [1:0] rank(input logic [1:0] r);
        return r == 2'b01 ? 2'd0 : r == 2'b00 ? 2'd1 : r;
    endfunction

    assign ARID    = '0;
    assign AWID    = '0;
    assign ARADDR  = addr_q;
    assign AWADDR  = addr_q;
    assign ARLEN   = len_q;
    assign AWLEN   = len_q;
    assign ARSIZE  = 3'($clog2(SW));
    assign AWSIZE  = 3'($clog2(SW));
    assign ARBURST = 2'b01;
    assign AWBURST = 2'b01;
    assign WDATA   = wd_data;
    assign rd_data = RDATA;
    assign sts_resp = resp_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        last      = cnt_q == {1'b0, len_q};
        cmd_ready = state_q == IDLE && !ARESET;
        ARVALID   = state_q == RD_A;
        RREADY    = state_q == RD_D && rd_ready;
        rd_valid  = state_q == RD_D && RVALID;
        rd_last   = state_q == RD_D && RLAST;
        AWVALID   = state_q == WR_A && !aw_done_q;
        WVALID    = state_q == WR_A && !w_done_q && wd_valid;
        wd_ready  = state_q == WR_A && !w_done_q && WREADY;
        WLAST     = state_q == WR_A && !w_done_q && last;
        WSTRB     = state_q == WR_A ? wd_strb : '1;
        BREADY    = state_q == WR_B;
        sts_valid = state_q == STS;
        sts_err   = state_q == STS && err_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d    = cmd_addr;
                len_d     = cmd_len;
                cnt_d     = '0;
                resp_d    = 2'b01;
                err_d     = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = cmd_we ? WR_A : RD_A;
            end
            RD_A: if (ARREADY) state_d = RD_D;
            RD_D: if (RVALID && rd_ready) begin
                resp_d = rank(RRESP) > rank(resp_q) ? RRESP : resp_q;
                err_d  = err_q | (RLAST != last) | (RID != '0);
                cnt_d  = cnt_q + 1'b1;
                state_d = last ? STS : RD_D;
            end
            WR_A: begin
                aw_done_d = aw_done_q | (AWVALID && AWREADY);
                if (WVALID && WREADY) begin
                    cnt_d    = cnt_q + 1'b1;
                    w_done_d = last;
                end
                state_d = aw_done_d && w_done_d ? WR_B : WR_A;
            end
            WR_B: if (BVALID) begin
                resp_d  = BRESP;
                err_d   = err_q | (BID != '0);
                state_d = STS;
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
        hs = (ARVALID && ARREADY) || (RVALID && RREADY) || (AWVALID && AWREADY) ||
             (WVALID && WREADY) || (BVALID && BREADY);
        wdt_d = 16'hFFFF;
        if (state_q inside {RD_A, RD_D, WR_A, WR_B}) begin
            wdt_d = hs ? 16'hFFFF : wdt_q - 1'b1;
            if (wdt_q == '0) begin
                ARVALID  = 1'b0;
                RREADY   = 1'b0;
                rd_valid = 1'b0;
                rd_last  = 1'b0;
                AWVALID  = 1'b0;
                WVALID   = 1'b0;
                wd_ready = 1'b0;
                WLAST    = 1'b0;
                BREADY   = 1'b0;
                err_d    = 1'b1;
                resp_d   = 2'b10;
                state_d  = STS;
            end
        end
`endif
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            resp_q    <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
            wdt_q     <= 16'hFFFF;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
            wdt_q     <= wdt_d;
`endif
        end
    end
endmodule
